mult_stream_ctrl: RTL and testbench

Stream adapter that sits directly around the shift-add `multiplier`. It sits upstream as the operand feeder and downstream as the product collector. It accepts operand pairs on a valid/ready interface and presents each pair on the multiplier inputs in its load cycle. It tracks the multiplier's 10-cycle stage sequence with a mirrored phase counter, captures the 16-bit product in the final stage, and queues products on a valid/ready output. Throughput is one product per 10 cycles.

---
 rtl/mult_stream_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mult_stream_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_stream_ctrl.sv
// -----------------------------------------------------------------------------
// mult_stream_ctrl
//
// Stream adapter wrapped around a 10-stage shift-add multiplier. Operand pairs
// arrive on a valid/ready interface and are held in a one-entry operand
// register. A held pair is presented on mult_in1/mult_in2 in a phase-0 cycle,
// which is the multiplier's load cycle. The product is captured from mult_out
// in phase 9 and queued in a small result FIFO that drains on a valid/ready
// output.
//
// The multiplier has no handshake of its own. This block therefore runs a
// phase counter that mirrors the multiplier's stage counter. Both counters are
// reset by mult_rst, and both wrap 9 -> 0.
//
// Ports
//   clk, rst_n           clock (shared with the multiplier), async active-low reset
//   in_valid/in_ready    operand handshake; in_a/in_b carry the pair
//   mult_rst             synchronous active-high reset to the multiplier
//   mult_in1/mult_in2    operands to the multiplier (0 when not launching)
//   mult_out             product from the multiplier
//   out_valid/out_ready  product handshake; out_data is the FIFO head
//   busy                 an operand is held or a product is in flight
//   phase                mirrored multiplier stage, 0..9
// -----------------------------------------------------------------------------
module mult_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mult_rst,
  output logic [WIDTH-1:0]   mult_in1,
  output logic [WIDTH-1:0]   mult_in2,
  input  logic [2*WIDTH-1:0] mult_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               busy,
  output logic [3:0]         phase
);

  localparam int DW = 2 * WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = CW + 1;
  localparam logic [3:0] LAST_PHASE = 4'd9;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                       mult_rst_q, mult_rst_d;
  logic [3:0]                 phase_q,    phase_d;
  logic                       op_full_q,  op_full_d;
  logic [WIDTH-1:0]           op_a_q,     op_a_d;
  logic [WIDTH-1:0]           op_b_q,     op_b_d;
  logic                       inflight_q, inflight_d;
  logic [DEPTH-1:0][DW-1:0]   mem_q,      mem_d;
  logic [PW-1:0]              wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]              count_q,    count_d;

  // Events at the coming edge
  logic          accept;
  logic          launch;
  logic          capture;
  logic          pop;
  logic [RW-1:0] reserved;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A launch reserves a FIFO slot for its product. A product is only issued
  // when stored plus in-flight results leave room. This guarantees the capture
  // in phase 9 always finds space, so the multiplier never needs to stall.
  always_comb begin
    reserved = {1'b0, count_q} + RW'(inflight_q);
    accept   = in_valid && !op_full_q;
    // mult_rst gating keeps a load from landing in the multiplier's reset cycle.
    launch   = !mult_rst_q && (phase_q == 4'd0) && op_full_q &&
               (reserved < RW'(DEPTH));
    capture  = (phase_q == LAST_PHASE) && inflight_q;
    pop      = (count_q != '0) && out_ready;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mult_rst_d = 1'b0;

    // Stays in step with the multiplier's stage: both clear under mult_rst.
    if (mult_rst_q || (phase_q == LAST_PHASE)) phase_d = '0;
    else                                       phase_d = phase_q + 4'd1;

    // Operand register. accept needs !op_full and launch needs op_full, so
    // the two never coincide.
    op_full_d = op_full_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    if (launch) op_full_d = 1'b0;
    if (accept) begin
      op_full_d = 1'b1;
      op_a_d    = in_a;
      op_b_d    = in_b;
    end

    // Launch happens in phase 0 and capture in phase 9, so they are exclusive.
    inflight_d = inflight_q;
    if (launch)       inflight_d = 1'b1;
    else if (capture) inflight_d = 1'b0;

    // Result FIFO
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (capture) begin
      mem_d[wr_ptr_q] = mult_out;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({capture, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_rst_q <= 1'b1;
      phase_q    <= '0;
      op_full_q  <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      inflight_q <= 1'b0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mult_rst_q <= mult_rst_d;
      phase_q    <= phase_d;
      op_full_q  <= op_full_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      inflight_q <= inflight_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Zero operands when not launching: an idle multiplier window then yields 0,
  // and that result is never captured.
  assign mult_in1  = launch ? op_a_q : '0;
  assign mult_in2  = launch ? op_b_q : '0;
  assign mult_rst  = mult_rst_q;
  assign in_ready  = !op_full_q;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign busy      = op_full_q || inflight_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_mult_stream_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for mult_stream_ctrl. A behavioural shift-add multiplier sits on the
// mult_* ports. Its stage counter restarts under mult_rst, it loads operands at
// the end of stage 0, and it shows the product only during stage 9. Outside
// stage 9 it drives junk, so a mistimed capture shows up as a wrong product.
// Every accepted pair queues a*b. Every pop must match the head of that queue.
// -----------------------------------------------------------------------------
module tb_mult_stream_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        mult_rst;
  logic [7:0]  mult_in1, mult_in2;
  logic [15:0] mult_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;
  logic [3:0]  phase;

  always #5 clk = ~clk;

  mult_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mult_rst(mult_rst), .mult_in1(mult_in1), .mult_in2(mult_in2),
    .mult_out(mult_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .phase(phase)
  );

  // Behavioural multiplier
  logic [3:0] stg = 4'd0;
  logic [7:0] ma = '0, mb = '0;
  always @(posedge clk) begin
    if (mult_rst) stg <= 4'd0;
    else begin
      stg <= (stg == 4'd9) ? 4'd0 : stg + 4'd1;
      if (stg == 4'd0) begin
        ma <= mult_in1;
        mb <= mult_in2;
      end
    end
  end
  assign mult_out = (stg == 4'd9) ? ({8'd0, ma} * {8'd0, mb}) : {4'hA, stg, 8'h5C};

  // Scoreboard and bookkeeping
  int unsigned vectors = 0, miscompares = 0;
  int unsigned exp_q[$];
  int unsigned pa[$], pb[$], pop_cyc[$];
  int unsigned cyc = 0, nacc = 0;
  logic last_acc = 1'b0, last_pop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update the model, check after.
  task automatic tick();
    logic acc, pp, hold, live;
    logic [15:0] pd;
    logic [7:0] a_s, b_s;
    #1;
    live = rst_n;
    acc  = live && in_valid && in_ready;
    pp   = live && out_valid && out_ready;
    hold = live && out_valid && !out_ready;
    pd   = out_data;
    a_s  = in_a;
    b_s  = in_b;
    @(posedge clk);
    #1;
    cyc++;
    last_acc = acc;
    last_pop = pp;
    if (acc) exp_q.push_back(int'(a_s) * int'(b_s));
    if (pp) begin
      if (exp_q.size() == 0) chk("pop_extra", 32'(exp_q.size()), 32'd1);
      else chk("pop_data", 32'(pd), exp_q.pop_front());
    end
    if (hold && rst_n) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(pd));
    end
    if (rst_n) chk("phase_align", 32'(phase), 32'(stg));
    if (phase != 4'd0) chk("idle_operands", {16'd0, mult_in1, mult_in2}, 32'd0);
    @(negedge clk);
  endtask

  // Stream queued pairs until want_pops products are seen or max_cyc expires.
  task automatic feed(input int max_cyc, input int want_pops);
    for (int i = 0; i < max_cyc; i++) begin
      if (pa.size() > 0) begin
        in_valid = 1'b1; in_a = 8'(pa[0]); in_b = 8'(pb[0]);
      end else in_valid = 1'b0;
      tick();
      if (last_acc) begin void'(pa.pop_front()); void'(pb.pop_front()); nacc++; end
      if (last_pop) pop_cyc.push_back(cyc);
      if (pop_cyc.size() >= want_pops) break;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic pbusy, found;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_mult_rst", 32'(mult_rst), 32'd1);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mult_in", {16'd0, mult_in1, mult_in2}, 32'd0);
    rst_n = 1'b1;
    #1 chk("rel_mult_rst_hi", 32'(mult_rst), 32'd1);
    tick();
    chk("rel_mult_rst_lo", 32'(mult_rst), 32'd0);
    chk("rel_phase0", 32'(phase), 32'd0);

    // ---- 13*11 accepted at phase 3: launch 7 edges later, valid 9 after that
    for (int i = 0; i < 20 && phase != 4'd3; i++) tick();
    chk("wait_phase3", 32'(phase), 32'd3);
    in_valid = 1'b1; in_a = 8'd13; in_b = 8'd11;
    tick();
    in_valid = 1'b0;
    chk("acc_13x11", 32'(last_acc), 32'd1);
    pbusy = 1'b0;
    for (n = 0; n < 40 && !out_valid; n++) begin pbusy = busy; tick(); end
    chk("lat_13x11", 32'(n), 32'd16);
    chk("busy_before_cap", 32'(pbusy), 32'd1);
    chk("busy_after_cap", 32'(busy), 32'd0);
    chk("data_143", 32'(out_data), 32'd143);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // ---- back-to-back pairs, products 10 cycles apart
    out_ready = 1'b1;
    pa = '{255, 0, 1}; pb = '{255, 200, 1};
    pop_cyc.delete();
    feed(200, 3);
    chk("b2b_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap1", pop_cyc[1] - pop_cyc[0], 32'd10);
      chk("b2b_gap2", pop_cyc[2] - pop_cyc[1], 32'd10);
    end

    // ---- backpressure: two queued, third held, fourth stalled
    out_ready = 1'b0;
    pa = '{3, 6, 10, 200}; pb = '{5, 7, 12, 100};
    nacc = 0; pop_cyc.delete();
    feed(60, 99);
    chk("bp_accepts", nacc, 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_data), 32'd15);
    out_ready = 1'b1;
    feed(200, 4);
    chk("bp_drain", 32'(pop_cyc.size()), 32'd4);

    // ---- push and pop on the same phase-9 edge
    out_ready = 1'b0;
    pa = '{9, 12}; pb = '{9, 12};
    nacc = 0; pop_cyc.delete(); found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (nacc == 2 && out_valid && phase == 4'd9 && busy && in_ready) begin
        found = 1'b1; break;
      end
      feed(1, 99);
    end
    chk("pp_setup", 32'(found), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_data", 32'(out_data), 32'd144);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pp_empty", 32'(exp_q.size()), 32'd0);
    chk("pp_out_valid", 32'(out_valid), 32'd0);

    // ---- reset mid-flight at phase 5
    out_ready = 1'b1;
    pa = '{50}; pb = '{60}; found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (phase == 4'd5 && busy && in_ready && pa.size() == 0) begin found = 1'b1; break; end
      feed(1, 99);
    end
    chk("mid_setup", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_mult_rst", 32'(mult_rst), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_phase", 32'(phase), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    #1 chk("mid_rel_mult_rst", 32'(mult_rst), 32'd1);
    tick();
    chk("mid_rel_phase", 32'(phase), 32'd0);
    chk("mid_rel_mult_rst_lo", 32'(mult_rst), 32'd0);
    pa = '{7}; pb = '{9}; pop_cyc.delete();
    feed(100, 1);
    chk("mid_fresh_pop", 32'(pop_cyc.size()), 32'd1);

    // ---- idle
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_mult_in", {16'd0, mult_in1, mult_in2}, 32'd0);
    end

    // ---- random traffic
    pa.delete(); pb.delete(); pop_cyc.delete();
    for (int i = 0; i < 25; i++) begin
      pa.push_back($urandom_range(0, 255));
      pb.push_back($urandom_range(0, 255));
    end
    for (int i = 0; i < 3000 && pop_cyc.size() < 25; i++) begin
      if (pa.size() > 0 && ($urandom % 4) != 0) begin
        in_valid = 1'b1; in_a = 8'(pa[0]); in_b = 8'(pb[0]);
      end else in_valid = 1'b0;
      out_ready = (($urandom % 3) != 0);
      tick();
      if (last_acc) begin void'(pa.pop_front()); void'(pb.pop_front()); end
      if (last_pop) pop_cyc.push_back(cyc);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand_pops", 32'(pop_cyc.size()), 32'd25);
    chk("rand_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
